// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for 640x480@60 and helpers to derive line/frame
// totals and sync-window bounds from the porch/sync widths.
package vga_timing_pkg;
  localparam int CNT_W   = 10;
  localparam int COLOR_W = 8;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FRONT_D  = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BACK_D   = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FRONT_D  = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BACK_D   = 33;

  function automatic int total(input int act, front, sync, back);
    return act + front + sync + back;
  endfunction

  function automatic int sync_start(input int act, front);
    return act + front;
  endfunction

  function automatic int sync_end(input int act, front, sync);
    return act + front + sync;
  endfunction

  localparam int H_TOTAL_D  = total(H_ACTIVE_D, H_FRONT_D, H_SYNC_D, H_BACK_D);
  localparam int V_TOTAL_D  = total(V_ACTIVE_D, V_FRONT_D, V_SYNC_D, V_BACK_D);
  localparam int HS_START_D = sync_start(H_ACTIVE_D, H_FRONT_D);
  localparam int HS_END_D   = sync_end(H_ACTIVE_D, H_FRONT_D, H_SYNC_D);
  localparam int VS_START_D = sync_start(V_ACTIVE_D, V_FRONT_D);
  localparam int VS_END_D   = sync_end(V_ACTIVE_D, V_FRONT_D, V_SYNC_D);

  // Raster flags carried through the delay line, asserted-high regardless of pin polarity.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_flags_t;
endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with async clear; keeps raster flags aligned with
// colour returned by the pixel source.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster generator: drives coordinates to the pixel source and retimes
// sync/blank so they leave alongside the colour that comes back.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FRONT  = H_FRONT_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BACK   = H_BACK_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FRONT  = V_FRONT_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BACK   = V_BACK_D,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   PIPE_LAT = 1
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  output logic [CNT_W-1:0]   oVGA_X,
  output logic [CNT_W-1:0]   oVGA_Y,
  output logic               oRequest,
  output logic               oFrameStart,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK_n,
  output logic               oVGA_SYNC_n
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  generate
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (PIPE_LAT < 1)) begin : g_param_err
      $error("vga_timing_ctrl: totals must fit 10-bit counters and PIPE_LAT >= 1");
    end
  endgenerate

  // One extra bit so a sync window ending exactly at 1024 still compares correctly.
  localparam logic [CNT_W:0]   H_ACT_C  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0]   V_ACT_C  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0]   HS_ST_C  = (CNT_W+1)'(sync_start(H_ACTIVE, H_FRONT));
  localparam logic [CNT_W:0]   HS_END_C = (CNT_W+1)'(sync_end(H_ACTIVE, H_FRONT, H_SYNC));
  localparam logic [CNT_W:0]   VS_ST_C  = (CNT_W+1)'(sync_start(V_ACTIVE, V_FRONT));
  localparam logic [CNT_W:0]   VS_END_C = (CNT_W+1)'(sync_end(V_ACTIVE, V_FRONT, V_SYNC));
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0]   r_h_cnt, r_v_cnt;
  logic [CNT_W:0]     w_h, w_v;
  logic               w_active;
  vga_flags_t         w_flags, w_flags_dly;
  logic [COLOR_W-1:0] r_r, r_g, r_b;
  logic               r_hs, r_vs, r_blank_n;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign w_h      = {1'b0, r_h_cnt};
  assign w_v      = {1'b0, r_v_cnt};
  assign w_active = (w_h < H_ACT_C) && (w_v < V_ACT_C);

  assign oRequest    = w_active;
  assign oVGA_X      = w_active ? r_h_cnt : '0;
  assign oVGA_Y      = w_active ? r_v_cnt : '0;
  assign oFrameStart = (r_h_cnt == '0) && (r_v_cnt == '0);

  assign w_flags.active = w_active;
  assign w_flags.hs     = (w_h >= HS_ST_C) && (w_h < HS_END_C);
  assign w_flags.vs     = (w_v >= VS_ST_C) && (w_v < VS_END_C);

  vga_delay_line #(
    .WIDTH($bits(vga_flags_t)),
    .DEPTH(PIPE_LAT)
  ) u_flag_dly (
    .iVGA_CLK(iVGA_CLK),
    .iRST_n  (iRST_n),
    .i_d     (w_flags),
    .o_q     (w_flags_dly)
  );

  // Colour is sampled in the same cycle its flags emerge from the delay line.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
      r_hs      <= ~H_POL;
      r_vs      <= ~V_POL;
      r_blank_n <= 1'b0;
    end else begin
      r_r       <= w_flags_dly.active ? iRed   : '0;
      r_g       <= w_flags_dly.active ? iGreen : '0;
      r_b       <= w_flags_dly.active ? iBlue  : '0;
      r_hs      <= w_flags_dly.hs ? H_POL : ~H_POL;
      r_vs      <= w_flags_dly.vs ? V_POL : ~V_POL;
      r_blank_n <= w_flags_dly.active;
    end
  end

  assign oVGA_R       = r_r;
  assign oVGA_G       = r_g;
  assign oVGA_B       = r_b;
  assign oVGA_HS      = r_hs;
  assign oVGA_VS      = r_vs;
  assign oVGA_BLANK_n = r_blank_n;
  assign oVGA_SYNC_n  = 1'b0;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size 640x480 instance (PIPE_LAT=1) and a
// shrunken raster instance (PIPE_LAT=3, active-high hsync) for frame-level timing.
module tb_vga_timing_ctrl;
  import vga_timing_pkg::*;

  localparam int B_HA = 640, B_HF = 16, B_HS = 96, B_HB = 48;
  localparam int B_VA = 480, B_VF = 10, B_VS = 2,  B_VB = 33, B_L = 1;
  localparam int S_HA = 20,  S_HF = 3,  S_HS = 5,  S_HB = 4;
  localparam int S_VA = 6,   S_VF = 2,  S_VS = 2,  S_VB = 2,  S_L = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;  // 32
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;  // 12
  localparam int B_HT = 800, B_VT = 525;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank_n;
  } dac_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   white = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic [9:0] b_x, b_y, s_x, s_y;
  logic       b_req, b_fs, s_req, s_fs;
  logic [7:0] b_ir, b_ig, b_ib, s_ir, s_ig, s_ib;
  logic [7:0] b_r, b_g, b_b, s_r, s_g, s_b;
  logic       b_hs, b_vs, b_bn, b_sn, s_hs, s_vs, s_bn, s_sn;

  vga_timing_ctrl #(
    .H_ACTIVE(B_HA), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_ACTIVE(B_VA), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE_LAT(B_L)
  ) u_big (
    .iVGA_CLK(clk), .iRST_n(rst_n), .oVGA_X(b_x), .oVGA_Y(b_y),
    .oRequest(b_req), .oFrameStart(b_fs), .iRed(b_ir), .iGreen(b_ig), .iBlue(b_ib),
    .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b), .oVGA_HS(b_hs), .oVGA_VS(b_vs),
    .oVGA_BLANK_n(b_bn), .oVGA_SYNC_n(b_sn)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .H_POL(1'b1), .V_POL(1'b0), .PIPE_LAT(S_L)
  ) u_small (
    .iVGA_CLK(clk), .iRST_n(rst_n), .oVGA_X(s_x), .oVGA_Y(s_y),
    .oRequest(s_req), .oFrameStart(s_fs), .iRed(s_ir), .iGreen(s_ig), .iBlue(s_ib),
    .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b), .oVGA_HS(s_hs), .oVGA_VS(s_vs),
    .oVGA_BLANK_n(s_bn), .oVGA_SYNC_n(s_sn)
  );

  // Pixel source models: colour = {X, Y, X+Y} returned PIPE_LAT cycles later.
  logic [B_L-1:0][23:0] b_src;
  logic [S_L-1:0][23:0] s_src;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_src <= '0;
      s_src <= '0;
    end else begin
      b_src[0] <= {b_x[7:0], b_y[7:0], 8'(b_x + b_y)};
      s_src[0] <= {s_x[7:0], s_y[7:0], 8'(s_x + s_y)};
      for (int i = 1; i < B_L; i++) b_src[i] <= b_src[i-1];
      for (int i = 1; i < S_L; i++) s_src[i] <= s_src[i-1];
    end
  end

  assign {b_ir, b_ig, b_ib} = white ? 24'hFFFFFF : b_src[B_L-1];
  assign {s_ir, s_ig, s_ib} = white ? 24'hFFFFFF : s_src[S_L-1];

  function automatic dac_t model(input int h, v, ha, hf, hsw, va, vf, vsw,
                                 input bit hp, vp, w);
    dac_t m;
    bit   act;
    act       = (h < ha) && (v < va);
    m.rgb     = !act ? 24'h0 : (w ? 24'hFFFFFF : {8'(h), 8'(v), 8'(h + v)});
    m.hs      = ((h >= ha + hf) && (h < ha + hf + hsw)) ? hp : !hp;
    m.vs      = ((v >= va + vf) && (v < va + vf + vsw)) ? vp : !vp;
    m.blank_n = act;
    return m;
  endfunction

  // Releases reset just after a falling edge; caller is then inside cycle 0 (h=v=0).
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({b_r, b_g, b_b, b_hs, b_vs, b_bn, b_sn} !== {24'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_big_dac: got rgb=%h hs=%b vs=%b bn=%b sn=%b", {b_r, b_g, b_b}, b_hs, b_vs, b_bn, b_sn);
    end
    n_chk++;
    if ({s_r, s_g, s_b, s_hs, s_vs, s_bn, s_sn} !== {24'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_small_dac: got rgb=%h hs=%b vs=%b bn=%b sn=%b (need hs=0 vs=1)", {s_r, s_g, s_b}, s_hs, s_vs, s_bn, s_sn);
    end
    n_chk++;
    if ({b_x, b_y, b_fs} !== {10'd0, 10'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_big_coord: got x=%0d y=%0d fs=%b need 0 0 1", b_x, b_y, b_fs);
    end
  endtask

  task automatic test_coords();
    int req_cnt = 0;
    do_reset();
    n_chk++;
    if ({b_x, b_y, b_req, b_fs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL coord_c0: got x=%0d y=%0d req=%b fs=%b need 0 0 1 1", b_x, b_y, b_req, b_fs);
    end
    for (int c = 0; c <= 800; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 800 && b_req === 1'b1) req_cnt++;
      if (c == 639) begin
        n_chk++;
        if ({b_x, b_req} !== {10'd639, 1'b1}) begin
          n_fail++;
          $display("FAIL coord_c639: got x=%0d req=%b need 639 1", b_x, b_req);
        end
      end
      if (c == 640) begin
        n_chk++;
        if ({b_x, b_req} !== {10'd0, 1'b0}) begin
          n_fail++;
          $display("FAIL coord_c640: got x=%0d req=%b need 0 0", b_x, b_req);
        end
      end
      if (c == 800) begin
        n_chk++;
        if ({b_x, b_y, b_req, b_fs} !== {10'd0, 10'd1, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL coord_line1: got x=%0d y=%0d req=%b fs=%b need 0 1 1 0", b_x, b_y, b_req, b_fs);
        end
      end
    end
    n_chk++;
    if (req_cnt != 640) begin
      n_fail++;
      $display("FAIL coord_req_count: got %0d need 640", req_cnt);
    end
  endtask

  task automatic test_line_timing();
    int  falls[$];
    int  hs_low = 0, vs_low = 0, blank = 0;
    int  b_rise = -1, s_rise = -1, s_hs_on = -1;
    logic prev_hs;
    do_reset();
    prev_hs = b_hs;
    for (int c = 0; c < 1700; c++) begin
      if (c > 0) @(negedge clk);
      if (prev_hs === 1'b1 && b_hs === 1'b0) falls.push_back(c);
      prev_hs = b_hs;
      if (c < 800 && b_hs === 1'b0) hs_low++;
      if (b_vs === 1'b0) vs_low++;
      if (c >= 2 && c < 802 && b_bn === 1'b0) blank++;
      if (b_rise < 0 && b_bn === 1'b1) b_rise = c;
      if (s_rise < 0 && s_bn === 1'b1) s_rise = c;
      if (s_hs_on < 0 && s_hs === 1'b1) s_hs_on = c;
    end
    n_chk++;
    if (falls.size() < 2 || falls[0] != 658 || falls[1] != 1458) begin
      n_fail++;
      $display("FAIL hs_start: got %0d falls first=%0d need 658 and 1458", falls.size(), falls.size() > 0 ? falls[0] : -1);
    end
    n_chk++;
    if (hs_low != 96) begin
      n_fail++;
      $display("FAIL hs_width: got %0d need 96", hs_low);
    end
    n_chk++;
    if (vs_low != 0) begin
      n_fail++;
      $display("FAIL vs_early: got %0d low cycles need 0", vs_low);
    end
    n_chk++;
    if (blank != 160) begin
      n_fail++;
      $display("FAIL blank_per_line: got %0d need 160", blank);
    end
    n_chk++;
    if (b_rise != B_L + 1 || s_rise != S_L + 1) begin
      n_fail++;
      $display("FAIL latency: got big=%0d small=%0d need %0d %0d", b_rise, s_rise, B_L + 1, S_L + 1);
    end
    n_chk++;
    if (s_hs_on != S_L + 1 + S_HA + S_HF) begin
      n_fail++;
      $display("FAIL small_hs_start: got %0d need %0d", s_hs_on, S_L + 1 + S_HA + S_HF);
    end
  endtask

  task automatic test_frame();
    int vfalls[$];
    int fs_at[$];
    int vs_low = 0, hs_on = 0, b_fs_cnt = 0;
    logic prev_vs;
    do_reset();
    prev_vs = s_vs;
    for (int c = 0; c < 3 * S_HT * S_VT + 10; c++) begin
      if (c > 0) @(negedge clk);
      if (prev_vs === 1'b1 && s_vs === 1'b0) vfalls.push_back(c);
      prev_vs = s_vs;
      if (c < S_HT * S_VT + S_L + 1 && s_vs === 1'b0) vs_low++;
      if (c >= S_L + 1 && c < S_L + 1 + S_HT && s_hs === 1'b1) hs_on++;
      if (s_fs === 1'b1) fs_at.push_back(c);
      if (b_fs === 1'b1) b_fs_cnt++;
    end
    n_chk++;
    if (vfalls.size() < 2 || vfalls[0] != 260 || vfalls[1] != 260 + S_HT * S_VT) begin
      n_fail++;
      $display("FAIL vs_start: got %0d falls first=%0d need 260 and %0d", vfalls.size(), vfalls.size() > 0 ? vfalls[0] : -1, 260 + S_HT * S_VT);
    end
    n_chk++;
    if (vs_low != S_VS * S_HT) begin
      n_fail++;
      $display("FAIL vs_width: got %0d need %0d", vs_low, S_VS * S_HT);
    end
    n_chk++;
    if (hs_on != S_HS) begin
      n_fail++;
      $display("FAIL small_hs_width: got %0d need %0d", hs_on, S_HS);
    end
    n_chk++;
    if (fs_at.size() != 4 || fs_at[0] != 0 || fs_at[1] != S_HT * S_VT) begin
      n_fail++;
      $display("FAIL frame_start: got %0d pulses second=%0d need 4 and %0d", fs_at.size(), fs_at.size() > 1 ? fs_at[1] : -1, S_HT * S_VT);
    end
    n_chk++;
    if (b_fs_cnt != 1) begin
      n_fail++;
      $display("FAIL big_frame_start: got %0d pulses need 1", b_fs_cnt);
    end
  endtask

  // Scoreboard: expected DAC word pushed for the coordinate issued this cycle,
  // popped PIPE_LAT+1 cycles later against the pins.
  task automatic test_pixel_data(input bit w);
    dac_t qb[$], qs[$];
    dac_t eb, es, gb, gs;
    int   bh = 0, bv = 0, sh = 0, sv = 0;
    white = w;
    do_reset();
    for (int i = 0; i <= B_L; i++) qb.push_back('{rgb: 24'h0, hs: 1'b1, vs: 1'b1, blank_n: 1'b0});
    for (int i = 0; i <= S_L; i++) qs.push_back('{rgb: 24'h0, hs: 1'b0, vs: 1'b1, blank_n: 1'b0});
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) @(negedge clk);
      qb.push_back(model(bh, bv, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, 1'b0, 1'b0, w));
      qs.push_back(model(sh, sv, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b1, 1'b0, w));
      eb = qb.pop_front();
      es = qs.pop_front();
      gb = {b_r, b_g, b_b, b_hs, b_vs, b_bn};
      gs = {s_r, s_g, s_b, s_hs, s_vs, s_bn};
      n_chk++;
      if (gb !== eb) begin
        n_fail++;
        $display("FAIL pixel_big w=%0d c=%0d: got %h need %h", w, c, gb, eb);
      end
      n_chk++;
      if (gs !== es) begin
        n_fail++;
        $display("FAIL pixel_small w=%0d c=%0d: got %h need %h", w, c, gs, es);
      end
      bh++;
      if (bh == B_HT) begin bh = 0; bv = (bv == B_VT - 1) ? 0 : bv + 1; end
      sh++;
      if (sh == S_HT) begin sh = 0; sv = (sv == S_VT - 1) ? 0 : sv + 1; end
    end
    white = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    repeat (4 * S_HT + 10) @(negedge clk);
    n_chk++;
    if ({s_x, s_y, b_bn, s_bn} !== {10'd10, 10'd4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL midframe_pre: got x=%0d y=%0d bn=%b/%b need 10 4 1/1", s_x, s_y, b_bn, s_bn);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({b_r, b_g, b_b, b_hs, b_vs, b_bn, b_sn, s_r, s_g, s_b, s_hs, s_vs, s_bn, s_sn}
        !== {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midframe_async: got big rgb=%h bn=%b small rgb=%h bn=%b hs=%b", {b_r, b_g, b_b}, b_bn, {s_r, s_g, s_b}, s_bn, s_hs);
    end
    n_chk++;
    if ({s_x, s_y, s_fs} !== {10'd0, 10'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL midframe_coord: got x=%0d y=%0d fs=%b need 0 0 1", s_x, s_y, s_fs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if ({b_x, b_y, b_fs, s_x, s_y, s_fs} !== {10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL midframe_release: got big %0d,%0d fs=%b small %0d,%0d fs=%b", b_x, b_y, b_fs, s_x, s_y, s_fs);
    end
    @(negedge clk);
    n_chk++;
    if ({b_x, b_fs, s_x, s_fs, s_bn} !== {10'd1, 1'b0, 10'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midframe_restart: got bx=%0d bfs=%b sx=%0d sfs=%b sbn=%b need 1 0 1 0 0", b_x, b_fs, s_x, s_fs, s_bn);
    end
  endtask

  initial begin
    test_reset();
    test_coords();
    test_line_timing();
    test_frame();
    test_pixel_data(1'b0);
    test_pixel_data(1'b1);
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Generates VGA raster timing and per-pixel coordinates for the pattern/bitstream stage, then accepts that stage's registered RGB response and drives the video DAC. Owns the H/V counters, sync pulses and blanking, and applies a delay line so sync and blank stay pixel-aligned with the returned colour. Sits between the pixel-clock PLL and the DAC pins; the pixel source sits in its coordinate→RGB loop.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, back porch (pixels)
V_ACTIVE, 480, visible lines
V_FRONT, 10, front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, back porch (lines)
H_POL, 0, hsync asserted level (0 = active-low)
V_POL, 0, vsync asserted level
PIPE_LAT, 1, cycles from oVGA_X/Y to valid iRed/iGreen/iBlue (≥1)

Ports:
iVGA_CLK  in  1  pixel clock
iRST_n  in  1  async active-low reset
oVGA_X  out  10  pixel column to source; 0 outside active area
oVGA_Y  out  10  pixel row to source; 0 outside active area
oRequest  out  1  high when oVGA_X/Y is an active pixel
oFrameStart  out  1  1-cycle pulse with coordinate (0,0)
iRed  in  8  colour from source, PIPE_LAT cycles after coordinate
iGreen  in  8  as above
iBlue  in  8  as above
oVGA_R  out  8  DAC red
oVGA_G  out  8  DAC green
oVGA_B  out  8  DAC blue
oVGA_HS  out  1  horizontal sync
oVGA_VS  out  1  vertical sync
oVGA_BLANK_n  out  1  low during blanking
oVGA_SYNC_n  out  1  constant 0 (no sync-on-green)

Behaviour:
- Reset iRST_n, asynchronous, active-low; clock iVGA_CLK. All flops async-cleared.
- Reset values: h_cnt=0, v_cnt=0, delay-line contents = blank/inactive; oVGA_R/G/B=0, oVGA_HS=~H_POL, oVGA_VS=~V_POL, oVGA_BLANK_n=0, oVGA_SYNC_n=0.
- H_TOTAL=H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). Counter origin = first active pixel.
- h_cnt increments each cycle; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps to 0 at V_TOTAL-1 coincident with h_cnt wrap.
- active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. oRequest=active; oVGA_X=active?h_cnt:0; oVGA_Y=active?v_cnt:0 (decoded from registered counters, zero added latency).
- hs_raw asserted for H_ACTIVE+H_FRONT ≤ h_cnt < H_ACTIVE+H_FRONT+H_SYNC; vs_raw asserted for V_ACTIVE+V_FRONT ≤ v_cnt < V_ACTIVE+V_FRONT+V_SYNC (whole lines, changes at h_cnt=0).
- oFrameStart=1 iff h_cnt==0 && v_cnt==0.
- active, hs_raw, vs_raw pass through PIPE_LAT-stage delay line; iRed/G/B sampled the same cycle the delayed flags emerge; one output register stage follows. Total latency counter→DAC pins = PIPE_LAT+1.
- Output RGB = delayed_active ? iRGB : 0. oVGA_BLANK_n = delayed_active.
- First line after reset: delay line emits blank for PIPE_LAT cycles, so pixel (0,0) of the first frame appears correctly at cycle PIPE_LAT+1; no partial sync pulse emitted.
- Reset mid-frame: outputs go to reset values immediately; restart at (0,0) on release.
- Counters 10-bit; parameters must satisfy H_TOTAL, V_TOTAL ≤ 1024 (elaboration check).

Decomposition:
- Package vga_timing_pkg: default 640x480@60 constants, derived H_TOTAL/V_TOTAL, sync-window start/end localparams, colour width (8).
- Sub-module vga_delay_line: parameterised WIDTH×DEPTH async-reset shift register, used for {active,hs,vs}.

Test Plan:
- Release reset -> cycle 0: oVGA_X=0, oVGA_Y=0, oRequest=1, oFrameStart=1; cycle 639: X=639; cycle 640: oRequest=0, X=0.
- Free-run one line, PIPE_LAT=1 -> oVGA_HS low for exactly 96 cycles starting cycle 658 (656+2); line period 800 cycles.
- Free-run one frame -> oVGA_VS low for 1600 cycles starting line 490; oFrameStart period 420000 cycles.
- Source model returning iRed=X[7:0] with 1-cycle latency -> oVGA_R at cycle n+2 equals X(n) for every active pixel; 0 and BLANK_n=0 on all 160 blank pixels/line.
- Hold iRed=iGreen=iBlue=255 -> RGB=0 whenever oVGA_BLANK_n=0, 255 otherwise; PIPE_LAT=3 build shifts all DAC outputs 2 cycles later.
- Assert reset at line 300 pixel 400 -> outputs at reset values same cycle; after release X=Y=0, oFrameStart=1.
